ps2_key_decoder: RTL and testbench

- Sits between the PS/2 byte receiver and the display/LED control FSM.
- Turns the raw scan-code byte stream (set 2) into whole key events. Each event carries the code, an extended flag and a break flag; prefixes, controller status bytes and typematic repeats are removed.
- Events are buffered in a small first-word-fall-through queue, so the consumer can pop them at its own pace.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/key_event_fifo.sv | 85 ++++++++
 rtl/ps2_key_decoder.sv | 110 +++++++++++
 tb/tb_ps2_key_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code decoder.
package ps2_pkg;

    // Scan-code set 2 prefix bytes
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;

    // Controller / keyboard status bytes that never form key events
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;
    localparam logic [7:0] PS2_BATERR = 8'hFC;

    // Which prefixes have been seen for the byte in progress
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } prefix_state_t;

    // One decoded key event, 10 bits wide
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    // True for bytes that are status/diagnostic traffic rather than key data
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_BAT)    || (b == PS2_ACK)  || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1) ||
               (b == PS2_BATERR);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through queue of key events with full/empty and a sticky
// overflow flag. A write while full is accepted only if a pop happens on the
// same edge.
module key_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en_i,
    input  key_event_t wr_data_i,
    input  logic       rd_en_i,
    output key_event_t rd_data_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    key_event_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DEPTH_C);
    assign overflow_o = overflow_q;

    // Head falls through; outputs read as zero when nothing is queued
    assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer, count and overflow next-state
    always_comb begin
        do_pop     = rd_en_i && !empty_o;
        do_push    = wr_en_i && (!full_o || do_pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (wr_en_i && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 decoder: strips prefixes and status bytes, optionally
// filters typematic repeats, and queues whole key events for the consumer.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rd_en,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    prefix_state_t state_q, state_d;
    key_event_t    evt;
    logic          evt_valid;
    logic [8:0]    last_make_q, last_make_d;
    logic          last_valid_q, last_valid_d;
    logic          emit;
    logic          same_key;
    key_event_t    head;

    // Prefix FSM: accumulate E0/F0, drop status bytes, emit on any other byte
    always_comb begin
        state_d   = state_q;
        evt_valid = 1'b0;
        evt       = '0;
        if (rx_done) begin
            if (is_status_byte(rx_data)) begin
                state_d = S_IDLE;
            end else if (rx_data == PS2_EXT) begin
                // From any state, E0 leaves only the extended prefix pending;
                // an E0 after F0 is a framing error and drops the break.
                state_d = S_EXT;
            end else if (rx_data == PS2_BRK) begin
                case (state_q)
                    S_IDLE:  state_d = S_BRK;
                    S_EXT:   state_d = S_EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else begin
                evt_valid = 1'b1;
                evt.ext   = (state_q == S_EXT) || (state_q == S_EXT_BRK);
                evt.brk   = (state_q == S_BRK) || (state_q == S_EXT_BRK);
                evt.code  = rx_data;
                state_d   = S_IDLE;
            end
        end
    end

    // Repeat filter: drop a make that matches the key still being held
    always_comb begin
        last_make_d  = last_make_q;
        last_valid_d = last_valid_q;
        emit         = evt_valid;
        same_key     = last_valid_q && (last_make_q == {evt.ext, evt.code});
        if (SUPPRESS_REPEAT != 0 && evt_valid) begin
            if (!evt.brk) begin
                if (same_key) begin
                    emit = 1'b0;
                end else begin
                    last_make_d  = {evt.ext, evt.code};
                    last_valid_d = 1'b1;
                end
            end else if (same_key) begin
                last_valid_d = 1'b0;
            end
        end
    end

    // FSM and filter state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_make_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_make_q  <= last_make_d;
            last_valid_q <= last_valid_d;
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (emit),
        .wr_data_i  (evt),
        .rd_en_i    (rd_en),
        .rd_data_o  (head),
        .empty_o    (empty),
        .full_o     (full),
        .overflow_o (overflow)
    );

    assign key_code  = head.code;
    assign key_ext   = head.ext;
    assign key_break = head.brk;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: two instances (repeat filter on/depth 4 and
// filter off/depth 8) share the stimulus and are checked every cycle against
// a queue-based reference model, plus a vector table and directed sequences.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       rd_en = 1'b0;

    logic [7:0] key_code0, key_code1;
    logic       key_ext0, key_ext1, key_break0, key_break1;
    logic       empty0, empty1, full0, full1, overflow0, overflow1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_key_decoder #(.FIFO_DEPTH(4), .SUPPRESS_REPEAT(1)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .rd_en(rd_en), .key_code(key_code0), .key_ext(key_ext0),
        .key_break(key_break0), .empty(empty0), .full(full0),
        .overflow(overflow0)
    );

    ps2_key_decoder #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(0)) dut_nr (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .rd_en(rd_en), .key_code(key_code1), .key_ext(key_ext1),
        .key_break(key_break1), .empty(empty1), .full(full1),
        .overflow(overflow1)
    );

    // ---------------- reference model ----------------
    // Events are {ext, brk, code}. Pending prefixes kept as two flags.
    logic [9:0] mq0[$];
    logic [9:0] mq1[$];
    bit         pend_ext, pend_brk;
    bit         ovf0, ovf1;
    logic [8:0] held_key;
    bit         held_valid;

    function automatic bit is_status(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        pend_ext = 0; pend_brk = 0;
        ovf0 = 0; ovf1 = 0;
        held_key = '0; held_valid = 0;
    endtask

    task automatic model_edge(input logic d, input logic [7:0] b, input logic r);
        bit         ev, emit0;
        logic [9:0] e;
        ev = 0;
        e  = '0;
        if (d) begin
            if (is_status(b)) begin
                pend_ext = 0; pend_brk = 0;
            end else if (b == 8'hE0) begin
                pend_ext = 1; pend_brk = 0;
            end else if (b == 8'hF0) begin
                pend_brk = 1;
            end else begin
                ev = 1;
                e  = {pend_ext, pend_brk, b};
                pend_ext = 0; pend_brk = 0;
            end
        end
        if (r && mq0.size() > 0) void'(mq0.pop_front());
        if (r && mq1.size() > 0) void'(mq1.pop_front());
        emit0 = ev;
        if (ev && !e[8]) begin
            if (held_valid && held_key == {e[9], e[7:0]}) emit0 = 0;
            else begin
                held_key = {e[9], e[7:0]};
                held_valid = 1;
            end
        end else if (ev && e[8] && held_valid && held_key == {e[9], e[7:0]}) begin
            held_valid = 0;
        end
        if (emit0) begin
            if (mq0.size() < 4) mq0.push_back(e);
            else ovf0 = 1;
        end
        if (ev) begin
            if (mq1.size() < 8) mq1.push_back(e);
            else ovf1 = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [9:0]  h0, h1;
        logic [12:0] exp0, act0, exp1, act1;
        h0   = (mq0.size() == 0) ? 10'd0 : mq0[0];
        h1   = (mq1.size() == 0) ? 10'd0 : mq1[0];
        exp0 = {h0[7:0], h0[9], h0[8], mq0.size() == 0, mq0.size() == 4, ovf0};
        exp1 = {h1[7:0], h1[9], h1[8], mq1.size() == 0, mq1.size() == 8, ovf1};
        act0 = {key_code0, key_ext0, key_break0, empty0, full0, overflow0};
        act1 = {key_code1, key_ext1, key_break1, empty1, full1, overflow1};
        chk({tag, " filt"},   32'(act0), 32'(exp0));
        chk({tag, " nofilt"}, 32'(act1), 32'(exp1));
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it
    task automatic step(input logic d, input logic [7:0] b, input logic r, input string tag);
        rx_done = d; rx_data = b; rd_en = r;
        @(posedge clk);
        model_edge(d, b, r);
        @(negedge clk);
        rx_done = 0; rx_data = 8'h00; rd_en = 0;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_all("reset_async");
        chk("reset_outs", {key_code0, key_ext0, key_break0, empty0, full0, overflow0},
            {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all("reset_rel");
    endtask

    task automatic drain();
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, "drain");
    endtask

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic       rd;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       empty;
    } vec_t;

    vec_t vt[12];

    byte unsigned pool[10] = '{8'h1C, 8'h75, 8'hE0, 8'hF0, 8'hAA, 8'hFA,
                               8'h1D, 8'hE0, 8'hF0, 8'h00};

    initial begin
        // make/break, extended make/break, plain after extended
        vt[0]  = '{1'b1, 8'h1C, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 8'hF0, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 8'h1C, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 8'h00, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 8'h75, 1'b0, 8'h75, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 8'hE0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 8'h75, 1'b0, 8'h75, 1'b1, 1'b1, 1'b0};
        vt[10] = '{1'b1, 8'h75, 1'b1, 8'h75, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

        model_reset();
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            step(vt[i].done, vt[i].data, vt[i].rd, "table_model");
            chk($sformatf("table[%0d]", i),
                {key_code0, key_ext0, key_break0, empty0},
                {vt[i].code, vt[i].ext, vt[i].brk, vt[i].empty});
        end

        // Typematic repeat: 1C x5 then F0 1C
        for (int i = 0; i < 5; i++) step(1'b1, 8'h1C, 1'b0, "rep_make");
        step(1'b1, 8'hF0, 1'b0, "rep_f0");
        step(1'b1, 8'h1C, 1'b0, "rep_brk");
        chk("rep_filt_head0", {key_code0, key_ext0, key_break0, empty0}, {8'h1C, 3'b000});
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rep_nofilt[%0d]", i), {key_code1, key_ext1, key_break1, empty1},
                (i < 5) ? {8'h1C, 3'b000} : {8'h1C, 3'b010});
            if (i == 1)
                chk("rep_filt_head1", {key_code0, key_ext0, key_break0, empty0}, {8'h1C, 3'b010});
            if (i == 2)
                chk("rep_filt_done", {key_code0, empty0}, {8'h00, 1'b1});
            step(1'b0, 8'h00, 1'b1, "rep_pop");
        end
        chk("rep_nofilt_done", {key_code1, empty1}, {8'h00, 1'b1});

        // Status bytes clear a pending F0
        step(1'b1, 8'hAA, 1'b0, "st_aa");
        step(1'b1, 8'hFA, 1'b0, "st_fa");
        step(1'b1, 8'hF0, 1'b0, "st_f0");
        step(1'b1, 8'hAA, 1'b0, "st_aa2");
        chk("st_none", {empty0, empty1}, 2'b11);
        step(1'b1, 8'h1C, 1'b0, "st_1c");
        chk("st_event", {key_code0, key_ext0, key_break0, empty0}, {8'h1C, 3'b000});
        drain();

        // Overflow: six distinct makes with no pops
        begin
            logic [7:0] codes[6];
            codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
            for (int i = 0; i < 6; i++) begin
                step(1'b1, codes[i], 1'b0, "ovf_fill");
                if (i == 3) chk("ovf_full4", {full0, overflow0}, 2'b10);
            end
            chk("ovf_flag", {full0, overflow0}, 2'b11);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ovf_order[%0d]", i), {key_code0, key_ext0, key_break0},
                    {codes[i], 2'b00});
                step(1'b0, 8'h00, 1'b1, "ovf_pop");
            end
            chk("ovf_empty", {key_code0, key_ext0, key_break0, empty0, overflow0},
                {8'h00, 2'b00, 1'b1, 1'b1});
        end
        drain();

        // Reset between E0 and 75
        step(1'b1, 8'hE0, 1'b0, "rst_e0");
        do_reset();
        step(1'b1, 8'h75, 1'b0, "rst_75");
        chk("rst_plain75", {key_code0, key_ext0, key_break0, empty0}, {8'h75, 3'b000});
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            logic       d, r;
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(pool[$urandom_range(0, 9)]);
            d = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 3);
            step(d, b, r, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
